// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encodings,
// opcode/funct constants, ALU operation codes and the per-state Moore outputs.
package mips_multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Also consumed by the datapath ALU, so these codes must stay in sync with it.
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
  } ctrl_t;

  function automatic ctrl_t moore_outputs(input state_t s);
    ctrl_t c;
    c = '0;
    c.alucontrol = ALU_ADD;
    case (s)
      S_FETCH:    c.alusrcb = 2'b01;
      S_DECODE:   c.alusrcb = 2'b11;
      S_MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMREAD:  c.iord = 1'b1;
      S_MEMWRITE: begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_EXECUTE:  c.alusrca = 1'b1;
      S_ALUWB:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BRANCH:   begin c.alusrca = 1'b1; c.alucontrol = ALU_SUB; c.pcsrc = 2'b01; end
      S_ADDIEX:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:   c.regwrite = 1'b1;
      S_JUMP:     c.pcsrc = 2'b10;
      default:    c.alusrcb = 2'b01;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder: ALU operation plus a legality flag.
module alu_decoder
  import mips_multicycle_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       legal
);

  always_comb begin
    alucontrol = ALU_ADD;
    legal      = 1'b1;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: legal      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: Moore outputs registered alongside the state,
// with handshake-gated enables and the illegal-op pulse decoded combinationally.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int unsigned ADDI_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     cur, nxt;
  ctrl_t      ctrl;
  logic       is_lw;
  logic       decode_ok;
  logic [2:0] dec_alu;
  logic       dec_legal;

  alu_decoder u_alu_decoder (
    .funct      (funct),
    .alucontrol (dec_alu),
    .legal      (dec_legal)
  );

  always_comb begin
    nxt       = S_FETCH;
    decode_ok = 1'b1;
    case (cur)
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE: if (dec_legal) nxt = S_EXECUTE; else decode_ok = 1'b0;
          OP_BEQ:   nxt = S_BRANCH;
          OP_ADDI:  if (ADDI_EN != 0) nxt = S_ADDIEX; else decode_ok = 1'b0;
          OP_J:     nxt = S_JUMP;
          default:  decode_ok = 1'b0;
        endcase
      end
      // op is not looked at here; the lw/sw choice was captured in DECODE.
      S_MEMADR:   nxt = is_lw ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  nxt = S_ALUWB;
      S_ADDIEX:   nxt = S_ADDIWB;
      default:    nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur   <= S_FETCH;
      ctrl  <= moore_outputs(S_FETCH);
      is_lw <= 1'b0;
    end else begin
      cur  <= nxt;
      ctrl <= moore_outputs(nxt);
      if (cur == S_DECODE) is_lw <= (op == OP_LW);
    end
  end

  assign state      = cur;
  assign alucontrol = (cur == S_EXECUTE) ? dec_alu : ctrl.alucontrol;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign iord       = ctrl.iord;
  assign memwrite   = ctrl.memwrite;
  assign regwrite   = ctrl.regwrite;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;

  // Input-dependent enables are masked by reset so they cannot fire while held.
  assign irwrite    = ~reset & (cur == S_FETCH) & mem_ready;
  assign pcen       = ~reset & (((cur == S_FETCH) & mem_ready) |
                                ((cur == S_BRANCH) & zero) |
                                (cur == S_JUMP));
  assign illegal_op = ~reset & ~decode_ok;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: directed scenarios plus randomized instruction streams
// checked against an instruction-level plan model.
module tb_mips_multicycle_control;
  import mips_multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic [2:0] alucontrol;
  logic       alusrca, iord, memwrite, irwrite, regwrite, regdst, memtoreg, pcen, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] state;

  logic [2:0] n_alucontrol;
  logic       n_alusrca, n_iord, n_memwrite, n_irwrite, n_regwrite, n_regdst, n_memtoreg, n_pcen, n_illegal_op;
  logic [1:0] n_alusrcb, n_pcsrc;
  logic [3:0] n_state;

  logic [15:0] obs;
  int total = 0;
  int bad   = 0;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .pcen(pcen), .pcsrc(pcsrc), .illegal_op(illegal_op), .state(state)
  );

  mips_multicycle_control #(.ADDI_EN(0)) dut_noaddi (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alucontrol(n_alucontrol), .alusrca(n_alusrca), .alusrcb(n_alusrcb), .iord(n_iord),
    .memwrite(n_memwrite), .irwrite(n_irwrite), .regwrite(n_regwrite), .regdst(n_regdst),
    .memtoreg(n_memtoreg), .pcen(n_pcen), .pcsrc(n_pcsrc), .illegal_op(n_illegal_op), .state(n_state)
  );

  always #5 clk = ~clk;

  assign obs = {alucontrol, alusrca, alusrcb, pcsrc, iord, memwrite, irwrite,
                regwrite, regdst, memtoreg, pcen, illegal_op};

  function automatic logic legal_fn(input logic [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
           f == 6'b100101 || f == 6'b101010;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected output word for a state, straight from the control table.
  function automatic logic [15:0] exp_vec(input state_t st, input logic [5:0] f,
                                          input logic mr, input logic z, input logic ill);
    logic [2:0] ac;
    logic       sa, io, mw, iw, rw, rd, mt, pe;
    logic [1:0] sb, ps;
    ac = 3'b010; sa = 0; sb = 2'b00; ps = 2'b00;
    io = 0; mw = 0; iw = 0; rw = 0; rd = 0; mt = 0; pe = 0;
    case (st)
      S_FETCH:    begin sb = 2'b01; iw = mr; pe = mr; end
      S_DECODE:   sb = 2'b11;
      S_MEMADR:   begin sa = 1; sb = 2'b10; end
      S_MEMREAD:  io = 1;
      S_MEMWRITE: begin io = 1; mw = 1; end
      S_MEMWB:    begin mt = 1; rw = 1; end
      S_EXECUTE:  begin sa = 1; ac = alu_of(f); end
      S_ALUWB:    begin rd = 1; rw = 1; end
      S_BRANCH:   begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      S_ADDIEX:   begin sa = 1; sb = 2'b10; end
      S_ADDIWB:   rw = 1;
      S_JUMP:     begin ps = 2'b10; pe = 1; end
      default:    ;
    endcase
    return {ac, sa, sb, ps, io, mw, iw, rw, rd, mt, pe, ill};
  endfunction

  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic mr, input logic z);
    @(posedge clk); #1;
    op = o; funct = f; mem_ready = mr; zero = z;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = 6'd0; funct = 6'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; op = 6'b000010; funct = 6'd0;
    #1;
    total++;
    if (state !== 4'(S_FETCH) || irwrite !== 1'b0 || pcen !== 1'b0 || memwrite !== 1'b0 ||
        regwrite !== 1'b0 || illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold state=%0d ir=%b pcen=%b mw=%b rw=%b ill=%b expected state=0 all 0",
               state, irwrite, pcen, memwrite, regwrite, illegal_op);
    end
    @(posedge clk); #1;
    total++;
    if (state !== 4'(S_FETCH) || irwrite !== 1'b0 || pcen !== 1'b0) begin
      bad++;
      $display("FAIL reset_clocked state=%0d ir=%b pcen=%b expected state=0 ir=0 pcen=0", state, irwrite, pcen);
    end
    do_reset();
  endtask

  task automatic test_add();
    do_reset();
    drive(6'd0, 6'd0, 1'b1, 1'b0);
    total++;
    if (state !== 4'(S_FETCH) || irwrite !== 1'b1 || pcen !== 1'b1 || alusrcb !== 2'b01) begin
      bad++;
      $display("FAIL add_fetch state=%0d ir=%b pcen=%b srcb=%b expected 0 1 1 01", state, irwrite, pcen, alusrcb);
    end
    drive(6'b000000, 6'b100000, 1'b1, 1'b0);
    total++;
    if (state !== 4'(S_DECODE) || alusrcb !== 2'b11 || illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL add_decode state=%0d srcb=%b ill=%b expected 1 11 0", state, alusrcb, illegal_op);
    end
    drive(6'b000000, 6'b100000, 1'b1, 1'b0);
    total++;
    if (state !== 4'(S_EXECUTE) || alucontrol !== 3'b010 || alusrca !== 1'b1 || alusrcb !== 2'b00) begin
      bad++;
      $display("FAIL add_execute state=%0d alu=%b srca=%b srcb=%b expected 6 010 1 00", state, alucontrol, alusrca, alusrcb);
    end
    drive(6'b111111, 6'b111111, 1'b1, 1'b0);
    total++;
    if (state !== 4'(S_ALUWB) || regwrite !== 1'b1 || regdst !== 1'b1 || memtoreg !== 1'b0) begin
      bad++;
      $display("FAIL add_aluwb state=%0d rw=%b rd=%b mt=%b expected 7 1 1 0", state, regwrite, regdst, memtoreg);
    end
    drive(6'd0, 6'd0, 1'b0, 1'b0);
    total++;
    if (state !== 4'(S_FETCH) || regwrite !== 1'b0) begin
      bad++;
      $display("FAIL add_refetch state=%0d rw=%b expected 0 0", state, regwrite);
    end
  endtask

  task automatic test_lw_stall();
    do_reset();
    drive(6'd0, 6'd0, 1'b1, 1'b0);
    drive(6'b100011, 6'd0, 1'b1, 1'b0);
    // sw opcode on op during MEMADR must not turn the load into a store
    drive(6'b101011, 6'd0, 1'b1, 1'b0);
    total++;
    if (state !== 4'(S_MEMADR) || alusrca !== 1'b1 || alusrcb !== 2'b10) begin
      bad++;
      $display("FAIL lw_memadr state=%0d srca=%b srcb=%b expected 2 1 10", state, alusrca, alusrcb);
    end
    for (int i = 0; i < 3; i++) begin
      drive(6'b101011, 6'd0, 1'b0, 1'b0);
      total++;
      if (state !== 4'(S_MEMREAD) || iord !== 1'b1 || regwrite !== 1'b0 || memtoreg !== 1'b0 || memwrite !== 1'b0) begin
        bad++;
        $display("FAIL lw_stall%0d state=%0d iord=%b rw=%b mt=%b mw=%b expected 3 1 0 0 0",
                 i, state, iord, regwrite, memtoreg, memwrite);
      end
    end
    drive(6'd0, 6'd0, 1'b1, 1'b0);
    total++;
    if (state !== 4'(S_MEMREAD)) begin
      bad++;
      $display("FAIL lw_ready state=%0d expected 3", state);
    end
    drive(6'd0, 6'd0, 1'b0, 1'b0);
    total++;
    if (state !== 4'(S_MEMWB) || regwrite !== 1'b1 || memtoreg !== 1'b1 || regdst !== 1'b0) begin
      bad++;
      $display("FAIL lw_memwb state=%0d rw=%b mt=%b rd=%b expected 4 1 1 0", state, regwrite, memtoreg, regdst);
    end
    drive(6'd0, 6'd0, 1'b0, 1'b0);
    total++;
    if (state !== 4'(S_FETCH) || regwrite !== 1'b0 || memtoreg !== 1'b0) begin
      bad++;
      $display("FAIL lw_after state=%0d rw=%b mt=%b expected 0 0 0", state, regwrite, memtoreg);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      drive(6'd0, 6'd0, 1'b1, 1'b0);
      drive(6'b000100, 6'd0, 1'b1, 1'b0);
      drive(6'd0, 6'd0, 1'b0, 1'(z));
      total++;
      if (state !== 4'(S_BRANCH) || pcen !== 1'(z) || pcsrc !== 2'b01 || alucontrol !== 3'b110) begin
        bad++;
        $display("FAIL beq_z%0d state=%0d pcen=%b pcsrc=%b alu=%b expected 8 %0d 01 110",
                 z, state, pcen, pcsrc, alucontrol, z);
      end
      drive(6'd0, 6'd0, 1'b0, 1'b0);
      total++;
      if (state !== 4'(S_FETCH) || pcen !== 1'b0) begin
        bad++;
        $display("FAIL beq_after_z%0d state=%0d pcen=%b expected 0 0", z, state, pcen);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(6'd0, 6'd0, 1'b1, 1'b0);
    drive(6'b111111, 6'd0, 1'b1, 1'b0);
    total++;
    if (state !== 4'(S_DECODE) || illegal_op !== 1'b1 || regwrite !== 1'b0 || memwrite !== 1'b0) begin
      bad++;
      $display("FAIL illegal_decode state=%0d ill=%b rw=%b mw=%b expected 1 1 0 0", state, illegal_op, regwrite, memwrite);
    end
    for (int i = 0; i < 2; i++) begin
      drive(6'b111111, 6'd0, 1'b0, 1'b0);
      total++;
      if (state !== 4'(S_FETCH) || illegal_op !== 1'b0 || regwrite !== 1'b0 || memwrite !== 1'b0) begin
        bad++;
        $display("FAIL illegal_after%0d state=%0d ill=%b rw=%b mw=%b expected 0 0 0 0",
                 i, state, illegal_op, regwrite, memwrite);
      end
    end
  endtask

  task automatic test_sw_reset();
    do_reset();
    drive(6'd0, 6'd0, 1'b1, 1'b0);
    drive(6'b101011, 6'd0, 1'b1, 1'b0);
    drive(6'd0, 6'd0, 1'b0, 1'b0);
    drive(6'd0, 6'd0, 1'b0, 1'b0);
    total++;
    if (state !== 4'(S_MEMWRITE) || memwrite !== 1'b1 || iord !== 1'b1) begin
      bad++;
      $display("FAIL sw_wait state=%0d mw=%b iord=%b expected 5 1 1", state, memwrite, iord);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (memwrite !== 1'b0 || state !== 4'(S_FETCH)) begin
      bad++;
      $display("FAIL sw_abort mw=%b state=%0d expected 0 0", memwrite, state);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(6'd0, 6'd0, 1'b1, 1'b0);
    total++;
    if (state !== 4'(S_FETCH) || irwrite !== 1'b1 || memwrite !== 1'b0) begin
      bad++;
      $display("FAIL sw_resume state=%0d ir=%b mw=%b expected 0 1 0", state, irwrite, memwrite);
    end
    drive(6'b000010, 6'd0, 1'b1, 1'b0);
    total++;
    if (state !== 4'(S_DECODE)) begin
      bad++;
      $display("FAIL sw_resume_decode state=%0d expected 1", state);
    end
  endtask

  task automatic test_slt_noaddi();
    do_reset();
    drive(6'd0, 6'd0, 1'b1, 1'b0);
    drive(6'b000000, 6'b101010, 1'b1, 1'b0);
    drive(6'b000000, 6'b101010, 1'b1, 1'b0);
    total++;
    if (state !== 4'(S_EXECUTE) || alucontrol !== 3'b111) begin
      bad++;
      $display("FAIL slt_execute state=%0d alu=%b expected 6 111", state, alucontrol);
    end
    drive(6'd0, 6'd0, 1'b1, 1'b0);
    drive(6'd0, 6'd0, 1'b1, 1'b0);
    drive(6'b001000, 6'd0, 1'b1, 1'b0);
    total++;
    if (illegal_op !== 1'b0 || n_illegal_op !== 1'b1 || n_state !== 4'(S_DECODE)) begin
      bad++;
      $display("FAIL addi_decode ill=%b noaddi_ill=%b noaddi_state=%0d expected 0 1 1",
               illegal_op, n_illegal_op, n_state);
    end
    drive(6'd0, 6'd0, 1'b0, 1'b0);
    total++;
    if (state !== 4'(S_ADDIEX) || n_state !== 4'(S_FETCH) || n_regwrite !== 1'b0) begin
      bad++;
      $display("FAIL addi_next state=%0d noaddi_state=%0d noaddi_rw=%b expected 9 0 0",
               state, n_state, n_regwrite);
    end
  endtask

  // Randomized instruction stream; each decoded instruction expands into a
  // list of remaining phases, memory phases waiting on mem_ready.
  task automatic test_random(input int n);
    state_t     exp_st;
    state_t     plan[$];
    logic [5:0] iop, ifn;
    logic       mr, z, ill;
    logic [15:0] ev;
    exp_st = S_FETCH;
    iop = 6'd0; ifn = 6'd0;
    do_reset();
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (exp_st == S_FETCH) begin
        ifn = 6'($urandom);
        case ($urandom_range(0, 8))
          0: iop = 6'b100011;
          1: iop = 6'b101011;
          2, 3: begin
            iop = 6'b000000;
            case ($urandom_range(0, 4))
              0: ifn = 6'b100000;
              1: ifn = 6'b100010;
              2: ifn = 6'b100100;
              3: ifn = 6'b100101;
              default: ifn = 6'b101010;
            endcase
          end
          4: iop = 6'b000100;
          5: iop = 6'b001000;
          6: iop = 6'b000010;
          7: iop = 6'b000000;
          default: iop = 6'($urandom);
        endcase
      end
      mr = ($urandom_range(0, 3) != 0);
      z  = 1'($urandom_range(0, 1));
      if (exp_st == S_DECODE || exp_st == S_EXECUTE) begin
        op = iop; funct = ifn;
      end else begin
        op = 6'($urandom); funct = 6'($urandom);
      end
      mem_ready = mr; zero = z;
      ill = 1'b0;
      if (exp_st == S_DECODE) begin
        plan = {};
        if (iop == 6'b100011)                      plan = {S_MEMADR, S_MEMREAD, S_MEMWB};
        else if (iop == 6'b101011)                 plan = {S_MEMADR, S_MEMWRITE};
        else if (iop == 6'b000000 && legal_fn(ifn)) plan = {S_EXECUTE, S_ALUWB};
        else if (iop == 6'b000100)                 plan = {S_BRANCH};
        else if (iop == 6'b001000)                 plan = {S_ADDIEX, S_ADDIWB};
        else if (iop == 6'b000010)                 plan = {S_JUMP};
        else                                       ill = 1'b1;
      end
      @(negedge clk);
      total++;
      if (state !== 4'(exp_st)) begin
        bad++;
        $display("FAIL rand_state cyc=%0d op=%b fn=%b got=%0d want=%0d", c, iop, ifn, state, exp_st);
      end
      ev = exp_vec(exp_st, funct, mr, z, ill);
      total++;
      if (obs !== ev) begin
        bad++;
        $display("FAIL rand_outputs cyc=%0d state=%0d got=%h want=%h", c, exp_st, obs, ev);
      end
      case (exp_st)
        S_FETCH: if (mr) exp_st = S_DECODE;
        S_MEMREAD, S_MEMWRITE: if (mr) exp_st = (plan.size() > 0) ? plan.pop_front() : S_FETCH;
        default: exp_st = (plan.size() > 0) ? plan.pop_front() : S_FETCH;
      endcase
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = 6'd0; funct = 6'd0;
    test_reset();
    test_add();
    test_lw_stall();
    test_beq();
    test_illegal();
    test_sw_reset();
    test_slt_noaddi();
    test_random(600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
